// File: rtl/bitplane_feeder_if.sv
// bitplane_feeder_if: operand load, start and bit-plane stream signals of bitplane_feeder.
// master = the feeder itself; slave = loader/consumer side. out_ready exists only with BITPLANE_BP_EN.
interface bitplane_feeder_if;
    logic         w_valid;
    logic [15:0]  w_data;
    logic         a_valid;
    logic [127:0] a_data;
    logic         start;
    logic         load_ready;
    logic         busy;
    logic         in_valid;
    logic [127:0] in_data1;
    logic [127:0] in_data2;
    logic [127:0] in_data3;
    logic [127:0] in_data4;
    logic         done;
`ifdef BITPLANE_BP_EN
    logic         out_ready;
`endif

    modport master (
        input  w_valid, w_data, a_valid, a_data, start,
`ifdef BITPLANE_BP_EN
        input  out_ready,
`endif
        output load_ready, busy, in_valid, in_data1, in_data2, in_data3, in_data4, done
    );

    modport slave (
        output w_valid, w_data, a_valid, a_data, start,
`ifdef BITPLANE_BP_EN
        output out_ready,
`endif
        input  load_ready, busy, in_valid, in_data1, in_data2, in_data3, in_data4, done
    );
endinterface

// File: rtl/bitplane_feeder.sv
// bitplane_feeder: buffers 32x4 weights and 4x32 activations, then streams 16 bit-plane partial-product beats.
// Define BITPLANE_BP_EN to add out_ready backpressure on the stream.
module bitplane_feeder (
    input  logic clk,
    input  logic rst,
    bitplane_feeder_if.master bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [4:0]   w_cnt_q, w_cnt_d;
    logic         w_full_q, w_full_d;
    logic [1:0]   a_cnt_q, a_cnt_d;
    logic         a_full_q, a_full_d;
    logic [3:0]   b_q, b_d;
    logic         in_valid_q, in_valid_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         load_ready_q, load_ready_d;
    logic [127:0] data_q [4];
    logic [127:0] data_d [4];
    logic [15:0]  w_mem_q [32];
    logic [15:0]  w_mem_d [32];
    logic [127:0] a_mem_q [4];
    logic [127:0] a_mem_d [4];

    logic         accept;
    logic         load;
    logic         last_beat;
    logic [3:0]   next_b;
    logic [1:0]   bit_sel;
    logic [127:0] act_row;
    logic [127:0] plane [4];

`ifdef BITPLANE_BP_EN
    assign accept = in_valid_q & bus.out_ready;
`else
    assign accept = in_valid_q;
`endif
    // The output register refills when empty or when its beat is taken
    assign load      = ~in_valid_q | accept;
    assign last_beat = accept & (b_q == 4'd15);
    assign next_b    = in_valid_q ? b_q + 4'd1 : b_q;
    assign bit_sel   = 2'd3 - next_b[1:0];
    assign act_row   = a_mem_q[next_b[3:2]];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            plane[c] = '0;
            for (int k = 0; k < 32; k++) begin
                plane[c][k*4 +: 4] = {4{act_row[k*4 + int'(bit_sel)]}} & w_mem_q[k][c*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        w_cnt_d    = w_cnt_q;
        w_full_d   = w_full_q;
        a_cnt_d    = a_cnt_q;
        a_full_d   = a_full_q;
        b_d        = b_q;
        in_valid_d = in_valid_q;
        done_d     = 1'b0;
        data_d     = data_q;
        w_mem_d    = w_mem_q;
        a_mem_d    = a_mem_q;
        case (state_q)
            IDLE: begin
                if (bus.w_valid && !w_full_q) begin
                    w_mem_d[w_cnt_q] = bus.w_data;
                    w_cnt_d          = w_cnt_q + 5'd1;
                    w_full_d         = (w_cnt_q == 5'd31);
                end
                if (bus.a_valid && !a_full_q) begin
                    a_mem_d[a_cnt_q] = bus.a_data;
                    a_cnt_d          = a_cnt_q + 2'd1;
                    a_full_d         = (a_cnt_q == 2'd3);
                end
                // Flags are registered, so a start alongside the completing write is not seen
                if (bus.start && w_full_q && a_full_q) begin
                    state_d = STREAM;
                    b_d     = 4'd0;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_d    = DONE;
                    in_valid_d = 1'b0;
                    done_d     = 1'b1;
                    b_d        = 4'd0;
                    w_cnt_d    = 5'd0;
                    w_full_d   = 1'b0;
                    a_cnt_d    = 2'd0;
                    a_full_d   = 1'b0;
                    for (int c = 0; c < 4; c++) data_d[c] = '0;
                end else if (load) begin
                    in_valid_d = 1'b1;
                    data_d     = plane;
                    b_d        = next_b;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d       = (state_d == STREAM);
        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            w_cnt_q      <= 5'd0;
            w_full_q     <= 1'b0;
            a_cnt_q      <= 2'd0;
            a_full_q     <= 1'b0;
            b_q          <= 4'd0;
            in_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
            for (int c = 0; c < 4; c++) data_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            w_cnt_q      <= w_cnt_d;
            w_full_q     <= w_full_d;
            a_cnt_q      <= a_cnt_d;
            a_full_q     <= a_full_d;
            b_q          <= b_d;
            in_valid_q   <= in_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
            data_q       <= data_d;
        end
    end

    // Operand storage needs no reset; contents are only used after a full reload
    always_ff @(posedge clk) begin
        w_mem_q <= w_mem_d;
        a_mem_q <= a_mem_d;
    end

    assign bus.load_ready = load_ready_q;
    assign bus.busy       = busy_q;
    assign bus.in_valid   = in_valid_q;
    assign bus.done       = done_q;
    assign bus.in_data1   = data_q[0];
    assign bus.in_data2   = data_q[1];
    assign bus.in_data3   = data_q[2];
    assign bus.in_data4   = data_q[3];

endmodule

// File: tb/tb_bitplane_feeder.sv
// Directed self-checking bench for bitplane_feeder; backpressure scenario only when BITPLANE_BP_EN is defined.
module tb_bitplane_feeder;

    logic clk;
    logic rst;

    bitplane_feeder_if bus ();

    bitplane_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] ONES = '1;

    int errors;
    int checks;

    logic [15:0]  wm [32];
    logic [127:0] am [4];

    logic [127:0] cap [16][4];
    logic         tr_valid [40];
    logic [127:0] tr_data [40][4];
    int cap_valid, cap_acc, first_v, last_v, done_at, done_cnt, lr_at;
    logic ready_now;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.start   = 1'b0;
`ifdef BITPLANE_BP_EN
        bus.out_ready = 1'b1;
`endif
    endtask

    task automatic fill_mats(input logic [15:0] wv, input logic [127:0] av);
        for (int k = 0; k < 32; k++) wm[k] = wv;
        for (int i = 0; i < 4; i++) am[i] = av;
    endtask

    task automatic load_rows(input int nw, input int na);
        int n;
        n = (nw > na) ? nw : na;
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            bus.w_valid = (r < nw);
            bus.w_data  = wm[r];
            bus.a_valid = (r < na);
            bus.a_data  = am[r % 4];
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
    endtask

    // Pulses start, then records 40 cycles; n = cycles after the accepting edge
    task automatic run_stream(input int stall_from, input int stall_to, input bit spam);
        cap_valid = 0; cap_acc = 0; first_v = -1; last_v = -1;
        done_at = -1; done_cnt = 0; lr_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            ready_now = !(n >= stall_from && n <= stall_to);
`ifdef BITPLANE_BP_EN
            bus.out_ready = ready_now;
`endif
            bus.w_valid = spam && (n <= 15);
            bus.w_data  = 16'hFFFF;
            bus.a_valid = spam && (n <= 15);
            bus.a_data  = ONES;
            tr_valid[n]   = bus.in_valid;
            tr_data[n][0] = bus.in_data1;
            tr_data[n][1] = bus.in_data2;
            tr_data[n][2] = bus.in_data3;
            tr_data[n][3] = bus.in_data4;
            if (bus.in_valid) begin
                cap_valid++;
                if (first_v < 0) first_v = n;
                last_v = n;
                if (ready_now) begin
                    if (cap_acc < 16) for (int c = 0; c < 4; c++) cap[cap_acc][c] = tr_data[n][c];
                    cap_acc++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n > 0 && lr_at < 0 && bus.load_ready) lr_at = n;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    function automatic int o_value(input int row, input int c);
        int acc;
        int s;
        acc = 0;
        for (int p = 0; p < 4; p++) begin
            s = 0;
            for (int k = 0; k < 32; k++) s += int'(cap[row*4 + p][c][k*4 +: 4]);
            acc = acc * 2 + s;
        end
        return acc;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_ready_in_reset got=%b want=1", bus.load_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_ready got=%b want=1", bus.load_ready); end
        checks++;
        if ({bus.busy, bus.in_valid, bus.done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got busy/valid/done=%b want=000", {bus.busy, bus.in_valid, bus.done}); end
        checks++;
        if ((bus.in_data1 | bus.in_data2 | bus.in_data3 | bus.in_data4) !== 128'h0) begin errors++; $display("[TB] FAIL reset_data got nonzero payload want=0"); end
    endtask

    task automatic test_all_ones();
        int bad;
        fill_mats(16'hFFFF, ONES);
        load_rows(32, 4);
        run_stream(-1, -1, 1'b0);
        checks++;
        if (cap_valid !== 16) begin errors++; $display("[TB] FAIL ones_valid_cycles got=%0d want=16", cap_valid); end
        checks++;
        if (first_v !== 1 || last_v !== 16) begin errors++; $display("[TB] FAIL ones_window got=%0d..%0d want=1..16", first_v, last_v); end
        checks++;
        if (done_at !== 17 || done_cnt !== 1) begin errors++; $display("[TB] FAIL ones_done got at=%0d count=%0d want at=17 count=1", done_at, done_cnt); end
        checks++;
        if (lr_at !== 18) begin errors++; $display("[TB] FAIL ones_load_ready_return got=%0d want=18", lr_at); end
        bad = 0;
        for (int b = 0; b < 16; b++) for (int c = 0; c < 4; c++) if (cap[b][c] !== ONES) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL ones_payload got %0d bad buses want=0", bad); end
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (o_value(i, c) !== 7200) begin errors++; $display("[TB] FAIL ones_O row=%0d col=%0d got=%0d want=7200", i, c, o_value(i, c)); end
            end
        end
    endtask

    task automatic load_sparse(input logic [15:0] w0, input logic [3:0] i00);
        fill_mats(16'h0, '0);
        wm[0] = w0;
        am[0][3:0] = i00;
    endtask

    task automatic test_sparse();
        int bad;
        load_sparse(16'h4321, 4'b1010);
        load_rows(32, 4);
        run_stream(-1, -1, 1'b0);
        for (int b = 0; b <= 2; b += 2) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (cap[b][c] !== 128'(c + 1)) begin errors++; $display("[TB] FAIL sparse_beat%0d_bus%0d got=%h want=%h", b, c + 1, cap[b][c], 128'(c + 1)); end
            end
        end
        bad = 0;
        for (int b = 0; b < 16; b++) if (b != 0 && b != 2) for (int c = 0; c < 4; c++) if (cap[b][c] !== 128'h0) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL sparse_zero_beats got %0d nonzero buses want=0", bad); end
    endtask

    task automatic test_partial_load();
        int seen;
        load_sparse(16'h4321, 4'b1010);
        load_rows(31, 4);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.in_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL partial_start_ignored got valid=%0d load_ready=%b want valid=0 load_ready=1", seen, bus.load_ready); end
        bus.w_valid = 1'b1;
        bus.w_data  = wm[31];
        bus.start   = 1'b1;
        @(negedge clk);
        idle_inputs();
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            if (bus.in_valid || bus.busy) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL start_with_last_write got active=%0d want=0", seen); end
        run_stream(-1, -1, 1'b0);
        checks++;
        if (first_v !== 1 || cap_valid !== 16) begin errors++; $display("[TB] FAIL partial_then_start got first=%0d valid=%0d want first=1 valid=16", first_v, cap_valid); end
        checks++;
        if (cap[0][0] !== 128'h1) begin errors++; $display("[TB] FAIL partial_payload got=%h want=1", cap[0][0]); end
    endtask

    task automatic test_write_during_stream();
        int bad;
        load_sparse(16'h4321, 4'b1010);
        load_rows(32, 4);
        run_stream(-1, -1, 1'b1);
        checks++;
        if (cap[0][0] !== 128'h1 || cap[0][3] !== 128'h4) begin errors++; $display("[TB] FAIL spam_beat0 got bus1=%h bus4=%h want 1 and 4", cap[0][0], cap[0][3]); end
        checks++;
        if (cap[2][1] !== 128'h2) begin errors++; $display("[TB] FAIL spam_beat2 got=%h want=2", cap[2][1]); end
        bad = 0;
        for (int b = 0; b < 16; b++) if (b != 0 && b != 2) for (int c = 0; c < 4; c++) if (cap[b][c] !== 128'h0) bad++;
        checks++;
        if (bad !== 0 || cap_valid !== 16) begin errors++; $display("[TB] FAIL spam_other_beats got bad=%0d valid=%0d want 0 and 16", bad, cap_valid); end
        load_sparse(16'h8765, 4'b1000);
        load_rows(32, 4);
        run_stream(-1, -1, 1'b0);
        checks++;
        if (cap[0][0] !== 128'h5 || cap[0][3] !== 128'h8) begin errors++; $display("[TB] FAIL reload_after_done got bus1=%h bus4=%h want 5 and 8", cap[0][0], cap[0][3]); end
        checks++;
        if (done_cnt !== 1 || cap[2][0] !== 128'h0) begin errors++; $display("[TB] FAIL reload_stream got done=%0d beat2=%h want 1 and 0", done_cnt, cap[2][0]); end
    endtask

    task automatic test_reset_midstream();
        int seen_v, seen_d;
        fill_mats(16'hFFFF, ONES);
        load_rows(32, 4);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.in_valid !== 1'b1 || bus.in_data1 !== ONES) begin errors++; $display("[TB] FAIL midstream_beat7 got valid=%b data1=%h want 1 and all ones", bus.in_valid, bus.in_data1); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_valid !== 1'b0 || (bus.in_data1 | bus.in_data2 | bus.in_data3 | bus.in_data4) !== 128'h0) begin errors++; $display("[TB] FAIL async_reset_outputs got valid=%b data1=%h want 0", bus.in_valid, bus.in_data1); end
        checks++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_flags got lr=%b busy=%b done=%b want 1 0 0", bus.load_ready, bus.busy, bus.done); end
        @(negedge clk);
        rst = 1'b0;
        seen_v = 0;
        seen_d = 0;
        for (int n = 0; n < 25; n++) begin
            if (bus.in_valid) seen_v++;
            if (bus.done) seen_d++;
            @(negedge clk);
        end
        checks++;
        if (seen_v !== 0 || seen_d !== 0) begin errors++; $display("[TB] FAIL after_reset_quiet got valid=%0d done=%0d want 0 0", seen_v, seen_d); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen_v = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.in_valid) seen_v++;
            @(negedge clk);
        end
        checks++;
        if (seen_v !== 0 || bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL start_without_reload got valid=%0d lr=%b want 0 1", seen_v, bus.load_ready); end
    endtask

`ifdef BITPLANE_BP_EN
    task automatic test_backpressure();
        int bad;
        fill_mats(16'h0, '0);
        wm[0] = 16'h4321;
        am[1][3:0] = 4'b0100;
        load_rows(32, 4);
        run_stream(6, 8, 1'b0);
        checks++;
        if (cap_valid !== 19 || cap_acc !== 16) begin errors++; $display("[TB] FAIL bp_counts got valid=%0d accepted=%0d want 19 16", cap_valid, cap_acc); end
        checks++;
        if (last_v !== 19 || done_at !== 20 || done_cnt !== 1) begin errors++; $display("[TB] FAIL bp_done got last=%0d done_at=%0d count=%0d want 19 20 1", last_v, done_at, done_cnt); end
        bad = 0;
        for (int n = 6; n <= 9; n++) if (!tr_valid[n] || tr_data[n][0] !== 128'h1 || tr_data[n][3] !== 128'h4) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL bp_hold got %0d bad stalled cycles want=0", bad); end
        checks++;
        if (cap[5][1] !== 128'h2 || cap[4][0] !== 128'h0 || cap[6][0] !== 128'h0) begin errors++; $display("[TB] FAIL bp_beats got b5=%h b4=%h b6=%h want 2 0 0", cap[5][1], cap[4][0], cap[6][0]); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        ready_now = 1'b1;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_all_ones();
        test_sparse();
        test_partial_load();
        test_write_during_stream();
        test_reset_midstream();
`ifdef BITPLANE_BP_EN
        test_backpressure();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitplane_feeder.md
# bitplane_feeder

Transmit-side producer for the bit-serial 4x32x4 matrix-multiply datapath. It buffers a 32x4 matrix of 4-bit weights and a 4x32 matrix of 4-bit activations. On start it emits the 16-beat bit-plane partial-product stream (in_valid, in_data1..in_data4) that the accumulate/shift consumer turns into the O1..O4 row results. It sits between the operand loader and the MAC array, and replaces the bench-side generator in system-level runs.

## Interface
Parameters:
- none (dimensions fixed: 32 columns, 4 rows, 4 outputs, 4-bit operands)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_valid  in  1  weight-row write strobe
- w_data  in  16  weight row k, ordered {W[k][3],W[k][2],W[k][1],W[k][0]}; rows written k=0..31 in order
- a_valid  in  1  activation-row write strobe
- a_data  in  128  activation row i; a_data[k*4+:4] = I[i][k]; rows written i=0..3 in order
- start  in  1  stream request
- load_ready  out  1  high when writes are accepted
- busy  out  1  high while streaming
- in_valid  out  1  stream beat valid
- in_data1..in_data4  out  128 each  beat payload, one bus per weight column 0..3
- done  out  1  one-cycle pulse after the last beat
- out_ready  in  1  downstream accept (only with BITPLANE_BP_EN)

## Operation
- FSM states:
  - IDLE: load_ready=1.
  - STREAM: busy=1, load_ready=0.
  - DONE: single cycle, done=1, then IDLE.
- Weight loading:
  - 5-bit write counter w_cnt; each w_valid while load_ready stores w_data into row w_cnt and increments it.
  - When w_cnt=31 is written, w_full is set and further w_valid is ignored.
- Activation loading:
  - 2-bit counter a_cnt and flag a_full, same rules.
  - Weight and activation writes are independent and may coincide.
- Start handling:
  - start is accepted only in IDLE with w_full && a_full.
  - Otherwise start is ignored, with no latching.
  - start in the same cycle as the completing write is ignored.
- Beat sequencing:
  - 4-bit beat counter b=0..15; row i=b[3:2], bit j=3-b[1:0] (MSB plane first).
- Beat payload:
  - For k=0..31 and c=0..3, in_data(c+1)[k*4+:4] = {4{I[i][k][j]}} & W[k][c].
- Stream completion:
  - On the final beat, w_full, a_full, w_cnt and a_cnt clear, and the FSM enters DONE.
  - A full reload is then required before the next start.
- Writes during STREAM/DONE are ignored.
- When in_valid=0, in_data1..4 are driven to zero.

## Timing
- Reset values:
  - load_ready=1 (in IDLE after reset).
  - All other outputs 0.
  - Counters and flags 0; stored matrices are don't-care.
- Reset asserted mid-stream:
  - Outputs go to reset values immediately (asynchronous).
  - The partial stream is abandoned and no done is issued.
- Latency and handshake:
  - start accepted at edge t gives beat 0 registered at edge t+1.
  - Without backpressure, in_valid is high for exactly 16 consecutive cycles, t+1..t+16.
  - done is high t+17..t+18 (one cycle); load_ready returns at t+18.
- No combinational path from any input to any output.

## Configuration
- BITPLANE_BP_EN defined:
  - Adds the out_ready port.
  - A beat advances only on in_valid && out_ready; payload and b are held stable while stalled.
  - done follows the final accepted beat by one cycle.
- BITPLANE_BP_EN undefined:
  - No out_ready port.
  - The stream is free-running for 16 cycles, matching the consumer, which has no stall.

## Test plan
- All W=15, all I=15, start:
  - Required: in_valid high 16 cycles; every beat all four buses = 128'hFFFF…F.
  - Required: done one cycle after the last beat; the consumer produces O1..O4=7200 for all rows.
- Only I[0][0]=4'b1010 and W[0]=16'h4321, all else 0:
  - Beats 0 and 2: in_data1..4[3:0]=1,2,3,4, all other nibbles 0.
  - Beats 1 and 3: all buses zero.
  - Beats 4..15: all zero.
- 31 weight rows and 4 activation rows loaded, then start:
  - No in_valid.
  - Write the 32nd row, wait one cycle, start: stream begins the next cycle.
- rst pulsed during beat 7:
  - Outputs zero immediately; no done; load_ready=1.
  - start with no reload is ignored.
- w_valid/a_valid with new data during STREAM:
  - Ignored; payload matches the pre-start matrices; counters are 0 after done.
- With BITPLANE_BP_EN, out_ready low for 3 cycles at beat 5:
  - Beat-5 payload held.
  - Stream spans 19 cycles with 16 accepted beats; done follows the last accepted beat.
